// File: rtl/chimp_sequencer.sv
// Chimp memory-game sequencer: clears the board, places numbers 1..count, then scores clicks.
// Optional macro CHIMP_SHOW_TIMEOUT_EN hides the numbers after SHOW_CYCLES clocks in SHOW.
module chimp_sequencer #(
  parameter int          START_COUNT = 4,
  parameter int          MAX_COUNT   = 9,
  parameter int          MAX_STRIKES = 3,
  parameter logic [23:0] SHOW_CYCLES = 24'd5_000_000
) (
  input  logic       clk,
  input  logic       iReset,
  input  logic       iStart,
  input  logic       iKey0,
  input  logic       iDoneLoad,
  input  logic       iClickValid,
  input  logic [4:0] iClickNum,
  output logic       oResetBoard,
  output logic       oLoadEnable,
  output logic [4:0] oNumToLoad,
  output logic       oShowEnable,
  output logic [4:0] oNumToChoose,
  output logic [4:0] oLevel,
  output logic [1:0] oStrikes,
  output logic       oGameOver,
  output logic       oWin
);

  typedef enum logic [3:0] {
    IDLE, CLEAR, LOAD, WAITLOAD, SHOW, PLAY, NEXT, STRIKE, OVER, WIN
  } stateT;

  localparam logic [4:0] START5   = 5'(START_COUNT);
  localparam logic [4:0] MAXCNT5  = 5'(MAX_COUNT);
  localparam logic [1:0] MAXSTR2  = 2'(MAX_STRIKES);

  stateT      state, nextState;
  logic [4:0] levelNext, numToLoadNext, numToChooseNext;
  logic [1:0] strikesNext;
  logic [4:0] count;
  logic       showTimeout;

  assign count = START5 + oLevel - 5'd1;

`ifdef CHIMP_SHOW_TIMEOUT_EN
  logic [23:0] showCount;

  assign showTimeout = (state == SHOW) && (showCount == SHOW_CYCLES - 24'd1);

  // Counts cycles spent in SHOW; zero on entry and whenever SHOW is left.
  always_ff @(posedge clk or negedge iReset) begin
    if (!iReset)
      showCount <= '0;
    else if (state == SHOW && nextState == SHOW)
      showCount <= showCount + 24'd1;
    else
      showCount <= '0;
  end
`else
  assign showTimeout = 1'b0;
`endif

  always_comb begin
    nextState       = state;
    levelNext       = oLevel;
    strikesNext     = oStrikes;
    numToLoadNext   = oNumToLoad;
    numToChooseNext = oNumToChoose;
    if (iKey0) begin
      nextState       = IDLE;
      levelNext       = 5'd1;
      strikesNext     = 2'd0;
      numToLoadNext   = 5'd0;
      numToChooseNext = 5'd0;
    end else begin
      unique case (state)
        IDLE, OVER, WIN: begin
          if (iStart) begin
            nextState     = CLEAR;
            levelNext     = 5'd1;
            strikesNext   = 2'd0;
            numToLoadNext = 5'd1;
          end
        end
        CLEAR: nextState = LOAD;
        LOAD:  nextState = WAITLOAD;
        WAITLOAD: begin
          if (iDoneLoad) begin
            if (oNumToLoad == count) begin
              nextState       = SHOW;
              numToChooseNext = 5'd1;
            end else begin
              nextState     = LOAD;
              numToLoadNext = oNumToLoad + 5'd1;
            end
          end
        end
        SHOW, PLAY: begin
          // An empty box (number 0) is not a guess at all.
          if (iClickValid && iClickNum != 5'd0) begin
            if (iClickNum == oNumToChoose) begin
              numToChooseNext = oNumToChoose + 5'd1;
              nextState       = (oNumToChoose == count) ? NEXT : PLAY;
            end else begin
              nextState   = STRIKE;
              strikesNext = (oStrikes >= MAXSTR2) ? oStrikes : oStrikes + 2'd1;
            end
          end else if (showTimeout) begin
            nextState = PLAY;
          end
        end
        NEXT: begin
          if (count == MAXCNT5) begin
            nextState = WIN;
          end else begin
            nextState     = CLEAR;
            levelNext     = oLevel + 5'd1;
            numToLoadNext = 5'd1;
          end
        end
        STRIKE: begin
          if (oStrikes == MAXSTR2) begin
            nextState = OVER;
          end else begin
            nextState     = CLEAR;
            numToLoadNext = 5'd1;
          end
        end
        default: nextState = IDLE;
      endcase
    end
  end

  // Flag outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge iReset) begin
    if (!iReset) begin
      state        <= IDLE;
      oLevel       <= 5'd1;
      oStrikes     <= 2'd0;
      oNumToLoad   <= 5'd0;
      oNumToChoose <= 5'd0;
      oResetBoard  <= 1'b0;
      oLoadEnable  <= 1'b0;
      oShowEnable  <= 1'b0;
      oGameOver    <= 1'b0;
      oWin         <= 1'b0;
    end else begin
      state        <= nextState;
      oLevel       <= levelNext;
      oStrikes     <= strikesNext;
      oNumToLoad   <= numToLoadNext;
      oNumToChoose <= numToChooseNext;
      oResetBoard  <= (nextState == CLEAR);
      oLoadEnable  <= (nextState == LOAD);
      oShowEnable  <= (nextState == LOAD) || (nextState == WAITLOAD) || (nextState == SHOW);
      oGameOver    <= (nextState == OVER);
      oWin         <= (nextState == WIN);
    end
  end

endmodule

// File: tb/tb_chimp_sequencer.sv
// Scoreboard bench for chimp_sequencer: stimulus queues expected board events, a monitor pops them.
module tb_chimp_sequencer;

  logic       clk = 1'b0;
  logic       iReset, iStart, iKey0, iDoneLoad, iClickValid;
  logic [4:0] iClickNum;
  logic       oResetBoard, oLoadEnable, oShowEnable, oGameOver, oWin;
  logic [4:0] oNumToLoad, oNumToChoose, oLevel;
  logic [1:0] oStrikes;

  always #5 clk = ~clk;

  chimp_sequencer dut (
    .clk(clk), .iReset(iReset), .iStart(iStart), .iKey0(iKey0),
    .iDoneLoad(iDoneLoad), .iClickValid(iClickValid), .iClickNum(iClickNum),
    .oResetBoard(oResetBoard), .oLoadEnable(oLoadEnable), .oNumToLoad(oNumToLoad),
    .oShowEnable(oShowEnable), .oNumToChoose(oNumToChoose), .oLevel(oLevel),
    .oStrikes(oStrikes), .oGameOver(oGameOver), .oWin(oWin)
  );

  // Event kinds: 0 board clear, 1 load request, 2 game over, 3 win. num < 0 means don't care.
  typedef struct {
    int kind;
    int level;
    int strikes;
    int num;
  } expT;

  expT  expQ[$];
  int   checks = 0;
  int   errors = 0;
  logic prevOver = 1'b0;
  logic prevWin  = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic pushExp(input int kind, input int lvl, input int str, input int num);
    expQ.push_back('{kind, lvl, str, num});
  endtask

  task automatic pushLevel(input int lvl, input int str, input int nLoads);
    pushExp(0, lvl, str, 1);
    for (int n = 1; n <= nLoads; n++) pushExp(1, lvl, str, n);
  endtask

  task automatic monitorEvent(input int kind);
    expT e;
    if (expQ.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL unexpectedEvent: got kind %0d, expected no event", kind);
      return;
    end
    e = expQ.pop_front();
    checkOutput("eventKind", kind, e.kind);
    checkOutput("eventLevel", oLevel, e.level);
    checkOutput("eventStrikes", oStrikes, e.strikes);
    if (e.num >= 0) checkOutput("eventNumToLoad", oNumToLoad, e.num);
    if (kind == 1) checkOutput("loadShowEnable", oShowEnable, 1);
  endtask

  always @(negedge clk) begin
    if (iReset) begin
      if (oResetBoard) monitorEvent(0);
      if (oLoadEnable) monitorEvent(1);
      if (oGameOver && !prevOver) monitorEvent(2);
      if (oWin && !prevWin) monitorEvent(3);
    end
    prevOver <= oGameOver;
    prevWin  <= oWin;
  end

  task automatic applyStimulus(input logic start, input logic key0, input logic doneLoad,
                               input logic clickValid, input logic [4:0] clickNum);
    iStart      = start;
    iKey0       = key0;
    iDoneLoad   = doneLoad;
    iClickValid = clickValid;
    iClickNum   = clickNum;
    @(posedge clk);
    #1;
    iStart      = 1'b0;
    iKey0       = 1'b0;
    iDoneLoad   = 1'b0;
    iClickValid = 1'b0;
    iClickNum   = 5'd0;
  endtask

  task automatic waitLoadEnable(output bit ok);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (oLoadEnable) begin
        ok = 1'b1;
        return;
      end
    end
    ok = 1'b0;
    checks++;
    errors++;
    $display("[TB] FAIL loadTimeout: got no oLoadEnable in 100 cycles, expected a load request");
  endtask

  task automatic serviceLoads(input int n);
    bit ok;
    for (int i = 1; i <= n; i++) begin
      waitLoadEnable(ok);
      if (!ok) return;
      @(posedge clk);
      #1;
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 5'd0);
    end
  endtask

  task automatic waitFlag(input bit wantWin, input string name);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (wantWin ? oWin : oGameOver) break;
    end
    checkOutput(name, wantWin ? oWin : oGameOver, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic playLevel(input int lvl, input bit last);
    int cnt;
    cnt = 3 + lvl;
    serviceLoads(cnt);
    checkOutput("showAfterLoad", oShowEnable, 1);
    checkOutput("chooseStart", oNumToChoose, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 5'd0);
    checkOutput("zeroClickShow", oShowEnable, 1);
    checkOutput("zeroClickChoose", oNumToChoose, 1);
    for (int k = 1; k <= cnt; k++) begin
      if (k == cnt) begin
        if (last) pushExp(3, lvl, 0, -1);
        else      pushLevel(lvl + 1, 0, cnt + 1);
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 5'(k));
      if (k == 1) checkOutput("hiddenAfterFirst", oShowEnable, 0);
      if (k < cnt) checkOutput("chooseNext", oNumToChoose, k + 1);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit ok;
    iReset = 1'b0; iStart = 1'b0; iKey0 = 1'b0; iDoneLoad = 1'b0;
    iClickValid = 1'b0; iClickNum = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetLevel", oLevel, 1);
    checkOutput("resetStrikes", oStrikes, 0);
    checkOutput("resetNumToLoad", oNumToLoad, 0);
    checkOutput("resetNumToChoose", oNumToChoose, 0);
    checkOutput("resetFlags", {oResetBoard, oLoadEnable, oShowEnable, oGameOver, oWin}, 0);
    iReset = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] level 1 then level 2 load");
    pushLevel(1, 0, 4);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    playLevel(1, 1'b0);

    $display("[TB] three strikes on level 2");
    for (int s = 1; s <= 3; s++) begin
      serviceLoads(5);
      checkOutput("strikeLevelShow", oShowEnable, 1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 5'd1);
      if (s == 3) pushExp(2, 2, 3, -1);
      else        pushLevel(2, s, 5);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 5'd3);
      checkOutput("strikeCount", oStrikes, s);
    end
    waitFlag(1'b0, "gameOver");

    $display("[TB] restart and win through level 6");
    pushLevel(1, 0, 4);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    checkOutput("restartLevel", oLevel, 1);
    checkOutput("restartStrikes", oStrikes, 0);
    checkOutput("restartOverCleared", oGameOver, 0);
    for (int lvl = 1; lvl <= 6; lvl++) playLevel(lvl, lvl == 6);
    waitFlag(1'b1, "win");

    $display("[TB] key0 during WAITLOAD with coincident iDoneLoad");
    pushLevel(1, 0, 3);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    checkOutput("winRestartLevel", oLevel, 1);
    serviceLoads(2);
    waitLoadEnable(ok);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 5'd0);
    checkOutput("key0Show", oShowEnable, 0);
    checkOutput("key0Load", oLoadEnable, 0);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("key0StaysIdle", oShowEnable, 0);

    $display("[TB] reset during WAITLOAD");
    pushLevel(1, 0, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    waitLoadEnable(ok);
    @(posedge clk);
    #1;
    iReset = 1'b0;
    #1;
    checkOutput("asyncResetShow", oShowEnable, 0);
    checkOutput("asyncResetNumToLoad", oNumToLoad, 0);
    iDoneLoad = 1'b1;
    #1;
    iReset = 1'b1;
    @(posedge clk);
    #1;
    iDoneLoad = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("postResetShow", oShowEnable, 0);
    checkOutput("postResetNumToLoad", oNumToLoad, 0);
    checkOutput("queueEmpty", expQ.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
